// File: rtl/dshot_frame_tx.sv
// DShot frame transmitter: takes an 11-bit throttle/command word plus a
// telemetry flag, appends the 4-bit DShot CRC, and serialises the 16-bit
// frame MSB-first as fixed-period pulses whose high time encodes each bit.
module dshot_frame_tx #(
    parameter int unsigned BIT_CYCLES = 80,
    parameter int unsigned T1H_CYCLES = 60,
    parameter int unsigned T0H_CYCLES = 30,
    parameter int unsigned GAP_CYCLES = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_valid,
    input  logic [10:0] throttle,
    input  logic        telemetry,
    output logic        frame_ready,
    output logic        dshot_out,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned CYC_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned GCNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t              r_state;
    logic [15:0]         r_frame;
    logic [3:0]          r_bit_idx;
    logic [CYC_W-1:0]    r_cyc;
    logic [GCNT_W-1:0]   r_gcnt;
    logic                r_dshot_out;
    logic                r_frame_ready;
    logic                r_busy;
    logic                r_frame_done;

    logic [11:0]         w_word;
    logic [3:0]          w_crc;
    logic [15:0]         w_frame;
    logic                w_accept;
    logic [31:0]         w_high_time;
    logic                w_bit_high;
    logic                w_last_cyc;
    logic                w_last_gap;
    logic                w_done_next;

    // Frame word and non-inverted DShot CRC over the three nibbles
    assign w_word      = {throttle, telemetry};
    assign w_crc       = w_word[3:0] ^ w_word[7:4] ^ w_word[11:8];
    assign w_frame     = {w_word, w_crc};
    assign w_accept    = frame_valid && r_frame_ready;

    // Pulse shaping for the bit currently on the line
    assign w_high_time = r_frame[r_bit_idx] ? 32'(T1H_CYCLES) : 32'(T0H_CYCLES);
    assign w_bit_high  = 32'(r_cyc) < w_high_time;
    assign w_last_cyc  = (r_cyc == CYC_W'(BIT_CYCLES - 1));
    assign w_last_gap  = (r_gcnt == GCNT_W'(GAP_CYCLES - 1));
    // The gap cycle about to start is the final one
    assign w_done_next = ((32'(r_gcnt) + 32'd2) == 32'(GAP_CYCLES));

    // Transmit FSM with registered line and handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_frame       <= 16'd0;
            r_bit_idx     <= 4'd0;
            r_cyc         <= '0;
            r_gcnt        <= '0;
            r_dshot_out   <= 1'b0;
            r_frame_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_dshot_out <= 1'b0;
                    if (w_accept) begin
                        r_frame       <= w_frame;
                        r_bit_idx     <= 4'd15;
                        r_cyc         <= '0;
                        r_state       <= S_SEND;
                        r_frame_ready <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end
                S_SEND: begin
                    r_dshot_out <= w_bit_high;
                    if (w_last_cyc) begin
                        r_cyc <= '0;
                        if (r_bit_idx == 4'd0) begin
                            r_state      <= S_GAP;
                            r_gcnt       <= '0;
                            r_frame_done <= (GAP_CYCLES == 1);
                        end else begin
                            r_bit_idx <= r_bit_idx - 4'd1;
                        end
                    end else begin
                        r_cyc <= r_cyc + CYC_W'(1);
                    end
                end
                S_GAP: begin
                    r_dshot_out <= 1'b0;
                    if (w_last_gap) begin
                        r_state       <= S_IDLE;
                        r_gcnt        <= '0;
                        r_frame_ready <= 1'b1;
                        r_busy        <= 1'b0;
                    end else begin
                        r_gcnt       <= r_gcnt + GCNT_W'(1);
                        r_frame_done <= w_done_next;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_dshot_out   <= 1'b0;
                    r_frame_ready <= 1'b1;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign frame_ready = r_frame_ready;
    assign dshot_out   = r_dshot_out;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_dshot_frame_tx.sv
// Directed bench for dshot_frame_tx: decodes the serial line back into
// frames and compares them against a queue of expected frame words.
module tb_dshot_frame_tx;

    localparam int unsigned BIT   = 80;
    localparam int unsigned T1H   = 60;
    localparam int unsigned T0H   = 30;
    localparam int unsigned GAP   = 40;
    localparam int unsigned PITCH = 16 * BIT + GAP + 1;
    localparam int unsigned SEND_END = 16 * BIT;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_valid;
    logic [10:0] throttle;
    logic        telemetry;
    logic        frame_ready;
    logic        dshot_out;
    logic        busy;
    logic        frame_done;

    int          cyc_cnt = 0;
    int          last_acc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] exp_q[$];

    dshot_frame_tx #(
        .BIT_CYCLES(BIT),
        .T1H_CYCLES(T1H),
        .T0H_CYCLES(T0H),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_valid(frame_valid),
        .throttle   (throttle),
        .telemetry  (telemetry),
        .frame_ready(frame_ready),
        .dshot_out  (dshot_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] mk_frame(input logic [10:0] t, input logic tl);
        logic [11:0] v;
        v = {t, tl};
        return {v, v[3:0] ^ v[7:4] ^ v[11:8]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait for ready, and step through the accept edge
    task automatic send(input string tag, input logic [10:0] t, input logic tl,
                        input logic [15:0] exp_frame, input bit hold);
        int waited;
        waited = 0;
        frame_valid = 1'b1;
        throttle    = t;
        telemetry   = tl;
        while (frame_ready !== 1'b1 && waited < 3000) begin
            tick();
            waited++;
        end
        chk({tag, "_ready_wait"}, 32'(waited < 3000), 32'd1);
        exp_q.push_back(exp_frame);
        tick();
        last_acc = cyc_cnt;
        if (!hold) frame_valid = 1'b0;
        chk({tag, "_acc_state"}, {29'd0, frame_ready, busy, dshot_out}, 32'b010);
    endtask

    // Follow one frame from the cycle after accept to the first idle cycle
    task automatic rx_frame(input string tag, input bit change, input logic [10:0] mid_thr);
        int          hi_cnt[16];
        logic [15:0] got;
        int          shape_err, gap_err, done_n, done_at, hs_err, b, c;
        foreach (hi_cnt[i]) hi_cnt[i] = 0;
        got = 16'd0;
        shape_err = 0; gap_err = 0; done_n = 0; done_at = -1; hs_err = 0;
        for (int t = 1; t <= int'(PITCH) - 1; t++) begin
            tick();
            if (change && t == 600) throttle = mid_thr;
            if (t <= int'(SEND_END)) begin
                b = 15 - (t - 1) / int'(BIT);
                c = (t - 1) % int'(BIT);
                if (dshot_out === 1'b1) begin
                    if (c != hi_cnt[b]) shape_err++;
                    hi_cnt[b]++;
                end else if (dshot_out !== 1'b0) begin
                    shape_err++;
                end
            end else if (dshot_out !== 1'b0) begin
                gap_err++;
            end
            if (frame_done === 1'b1) begin
                done_n++;
                done_at = t;
            end
            if (t <= int'(PITCH) - 2 && (frame_ready !== 1'b0 || busy !== 1'b1)) hs_err++;
        end
        for (int i = 0; i < 16; i++) begin
            if (hi_cnt[i] == int'(T1H))      got[i] = 1'b1;
            else if (hi_cnt[i] == int'(T0H)) got[i] = 1'b0;
            else                             shape_err++;
        end
        if (exp_q.size() == 0) begin
            n_chk++;
            $error("FAIL %s_frame: observed %0h expected none (scoreboard empty)", tag, got);
        end else begin
            chk({tag, "_frame"}, 32'(got), 32'(exp_q.pop_front()));
        end
        chk({tag, "_shape_err"}, 32'(shape_err), 32'd0);
        chk({tag, "_gap_high"}, 32'(gap_err), 32'd0);
        chk({tag, "_done_count"}, 32'(done_n), 32'd1);
        chk({tag, "_done_cycle"}, 32'(done_at), 32'(PITCH - 2));
        chk({tag, "_busy_ready"}, 32'(hs_err), 32'd0);
        chk({tag, "_end_state"}, {30'd0, frame_ready, busy}, 32'b10);
    endtask

    initial begin
        int a1, dn;
        rst = 1'b1; frame_valid = 1'b0; throttle = 11'd0; telemetry = 1'b0;
        tick(); tick(); tick();
        chk("reset_state", {28'd0, frame_ready, busy, dshot_out, frame_done}, 32'b1000);

        // Reset wins over a simultaneous request
        frame_valid = 1'b1; throttle = 11'd1046;
        tick();
        chk("rst_vs_valid", {28'd0, frame_ready, busy, dshot_out, frame_done}, 32'b1000);
        frame_valid = 1'b0; rst = 1'b0;
        tick();
        chk("idle_after_rst", {29'd0, frame_ready, busy, dshot_out}, 32'b100);

        send("t1046", 11'd1046, 1'b0, 16'h82C6, 1'b0);
        rx_frame("t1046", 1'b0, 11'd0);
        send("t0", 11'd0, 1'b0, 16'h0000, 1'b0);
        rx_frame("t0", 1'b0, 11'd0);
        send("t2047", 11'd2047, 1'b1, 16'hFFFF, 1'b0);
        rx_frame("t2047", 1'b0, 11'd0);
        send("t1", 11'd1, 1'b1, 16'h0033, 1'b0);
        rx_frame("t1", 1'b0, 11'd0);

        // Held request with throttle changing mid-frame
        send("b2b_a", 11'd500, 1'b0, mk_frame(11'd500, 1'b0), 1'b1);
        a1 = last_acc;
        rx_frame("b2b_a", 1'b1, 11'd1234);
        send("b2b_b", 11'd1234, 1'b0, mk_frame(11'd1234, 1'b0), 1'b0);
        chk("b2b_pitch", 32'(last_acc - a1), 32'(PITCH));
        rx_frame("b2b_b", 1'b0, 11'd0);

        // Reset in the middle of a frame abandons it
        send("abort", 11'd300, 1'b1, mk_frame(11'd300, 1'b1), 1'b0);
        dn = 0;
        for (int t = 1; t <= 499; t++) begin
            tick();
            if (frame_done === 1'b1) dn++;
        end
        chk("abort_pre_high", {31'd0, dshot_out}, 32'd1);
        rst = 1'b1;
        tick();
        chk("abort_rst_edge", {28'd0, frame_ready, busy, dshot_out, frame_done}, 32'b1000);
        rst = 1'b0;
        void'(exp_q.pop_front());
        for (int t = 0; t < 60; t++) begin
            tick();
            if (frame_done === 1'b1 || dshot_out !== 1'b0 || frame_ready !== 1'b1) dn++;
        end
        chk("abort_quiet", 32'(dn), 32'd0);

        send("after_abort", 11'd1046, 1'b1, 16'h82D7, 1'b0);
        rx_frame("after_abort", 1'b0, 11'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
